// File: rtl/hex_msg_pkg.sv
// Shared definitions for the scrolling-message controller: FSM state
// encoding, the blank character code and the scroll-mode constants.
package hex_msg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        ROTATE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int unsigned BLANK       = 0;
    localparam logic        ONESHOT     = 1'b0;
    localparam logic        ROTATE_MODE = 1'b1;

endpackage

// File: rtl/hex_msg_store.sv
// Message memory: MAX_LEN x CHAR_W register file, cleared to BLANK on reset,
// one synchronous write port and one combinational read port.
module hex_msg_store
    import hex_msg_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CHAR_W  = 5,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [CHAR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [CHAR_W-1:0] rdata_o
);

    logic [CHAR_W-1:0] mem_q [MAX_LEN];

    // Storage array; out-of-range writes are dropped here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                mem_q[i] <= CHAR_W'(BLANK);
            end
        end else if (we_i && (32'(waddr_i) < 32'(MAX_LEN))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port, returning BLANK for addresses past the array.
    always_comb begin
        rdata_o = CHAR_W'(BLANK);
        if (32'(raddr_i) < 32'(MAX_LEN)) begin
            rdata_o = mem_q[raddr_i];
        end else begin
            rdata_o = CHAR_W'(BLANK);
        end
    end

endmodule

// File: rtl/hex_msg_scroller.sv
// Scrolling-message controller: shifts a stored message plus PAD blanks into
// a NUM_DIGITS-wide window, then holds (one-shot) or rotates forever.
module hex_msg_scroller
    import hex_msg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int MAX_LEN    = 8,
    parameter int PAD        = 3,
    parameter int CHAR_W     = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tick_i,
    input  logic                           pause_i,
    input  logic                           start_i,
    input  logic                           stop_i,
    input  logic                           mode_i,
    input  logic [$clog2(MAX_LEN+1)-1:0]   msg_len_i,
    input  logic                           load_i,
    input  logic [$clog2(MAX_LEN)-1:0]     load_addr_i,
    input  logic [CHAR_W-1:0]              load_char_i,
    output logic [NUM_DIGITS*CHAR_W-1:0]   window_o,
    output logic                           busy_o,
    output logic                           rotating_o,
    output logic                           done_o,
    output logic [1:0]                     current_state_o
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int POS_W  = $clog2(MAX_LEN + PAD);
    localparam int WIN_W  = NUM_DIGITS * CHAR_W;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               mode_q, mode_d;
    logic [WIN_W-1:0]   window_q, window_d;
    logic               done_q, done_d;
    logic               we_s;
    logic [CHAR_W-1:0]  rd_data_s;
    logic [CHAR_W-1:0]  stream_char_s;
    logic               step_s;
    logic               at_last_s;
    logic               len_ok_s;

    hex_msg_store #(
        .MAX_LEN (MAX_LEN),
        .CHAR_W  (CHAR_W),
        .ADDR_W  (ADDR_W)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we_s),
        .waddr_i (load_addr_i),
        .wdata_i (load_char_i),
        .raddr_i (ADDR_W'(pos_q)),
        .rdata_o (rd_data_s)
    );

    // Positions past the message body are the trailing blank pad.
    assign stream_char_s = (32'(pos_q) < 32'(len_q)) ? rd_data_s : CHAR_W'(BLANK);
    assign step_s        = tick_i && !pause_i;
    assign at_last_s     = (32'(pos_q) == (32'(len_q) + 32'(PAD) - 32'd1));
    assign len_ok_s      = (msg_len_i != LEN_W'(0)) && (32'(msg_len_i) <= 32'(MAX_LEN));

    // State, position, latched parameters, window and done pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            len_q    <= '0;
            mode_q   <= ONESHOT;
            window_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            window_q <= window_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; Stop outranks Start, which outranks a scroll step.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        len_d    = len_q;
        mode_d   = mode_q;
        window_d = window_q;
        done_d   = 1'b0;
        we_s     = 1'b0;
        case (state_q)
            IDLE: begin
                window_d = '0;
                we_s     = load_i;
                if (stop_i) begin
                    state_d = IDLE;
                end else if (start_i && len_ok_s) begin
                    state_d = FILL;
                    len_d   = msg_len_i;
                    mode_d  = mode_i;
                    pos_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL, ROTATE: begin
                if (stop_i) begin
                    state_d  = IDLE;
                    window_d = '0;
                    pos_d    = '0;
                end else if (step_s) begin
                    window_d = {window_q[WIN_W-CHAR_W-1:0], stream_char_s};
                    pos_d    = at_last_s ? POS_W'(0) : pos_q + POS_W'(1);
                    if ((state_q == FILL) && at_last_s) begin
                        if (mode_q == ROTATE_MODE) begin
                            state_d = ROTATE;
                        end else begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (stop_i || start_i) begin
                    state_d  = IDLE;
                    window_d = '0;
                    pos_d    = '0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d  = IDLE;
                window_d = '0;
                pos_d    = '0;
            end
        endcase
    end

    assign window_o        = window_q;
    assign busy_o          = (state_q == FILL) || (state_q == ROTATE);
    assign rotating_o      = (state_q == ROTATE);
    assign done_o          = done_q;
    assign current_state_o = state_q;

endmodule

// File: tb/tb_hex_msg_scroller.sv
// Directed and randomized bench for hex_msg_scroller, checked against a
// step-count based reference model of the scrolling stream.
module tb_hex_msg_scroller;

    localparam int ND = 8;
    localparam int ML = 8;
    localparam int PD = 3;
    localparam int CW = 5;
    localparam int S_IDLE = 0, S_FILL = 1, S_ROT = 2, S_HOLD = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            tick_i, pause_i, start_i, stop_i, mode_i, load_i;
    logic [3:0]      msg_len_i;
    logic [2:0]      load_addr_i;
    logic [CW-1:0]   load_char_i;
    logic [ND*CW-1:0] window_o;
    logic            busy_o, rotating_o, done_o;
    logic [1:0]      current_state_o;

    int checks = 0;
    int failures = 0;
    string phase = "reset";

    // Reference model: window is derived from the number of steps taken.
    int mstate, msteps, mlen, mmode, mdone;
    int mmem [ML];

    hex_msg_scroller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick_i          (tick_i),
        .pause_i         (pause_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .mode_i          (mode_i),
        .msg_len_i       (msg_len_i),
        .load_i          (load_i),
        .load_addr_i     (load_addr_i),
        .load_char_i     (load_char_i),
        .window_o        (window_o),
        .busy_o          (busy_o),
        .rotating_o      (rotating_o),
        .done_o          (done_o),
        .current_state_o (current_state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [ND*CW-1:0] exp_window();
        logic [ND*CW-1:0] w;
        int len_total, j, idx;
        w = '0;
        len_total = mlen + PD;
        if (mstate != S_IDLE) begin
            for (int d = 0; d < ND; d++) begin
                j = msteps - 1 - d;
                if (j >= 0) begin
                    idx = j % len_total;
                    w[d*CW +: CW] = (idx < mlen) ? CW'(mmem[idx]) : CW'(0);
                end
            end
        end
        return w;
    endfunction

    function automatic logic [ND*CW-1:0] pack8(input int d7, d6, d5, d4, d3, d2, d1, d0);
        return {CW'(d7), CW'(d6), CW'(d5), CW'(d4), CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
    endfunction

    task automatic model_reset();
        mstate = S_IDLE; msteps = 0; mlen = 0; mmode = 0; mdone = 0;
        for (int i = 0; i < ML; i++) mmem[i] = 0;
    endtask

    task automatic model_step();
        mdone = 0;
        case (mstate)
            S_IDLE: begin
                if (load_i && (int'(load_addr_i) < ML)) mmem[load_addr_i] = int'(load_char_i);
                if (!stop_i && start_i && msg_len_i >= 1 && int'(msg_len_i) <= ML) begin
                    mstate = S_FILL; mlen = int'(msg_len_i); mmode = int'(mode_i); msteps = 0;
                end
            end
            S_FILL, S_ROT: begin
                if (stop_i) mstate = S_IDLE;
                else if (tick_i && !pause_i) begin
                    msteps++;
                    if (mstate == S_FILL && msteps == mlen + PD) begin
                        if (mmode == 1) mstate = S_ROT;
                        else begin mstate = S_HOLD; mdone = 1; end
                    end
                end
            end
            S_HOLD: if (stop_i || start_i) mstate = S_IDLE;
            default: mstate = S_IDLE;
        endcase
    endtask

    task automatic check_all();
        chk("state", 64'(current_state_o), 64'(mstate));
        chk("window", 64'(window_o), 64'(exp_window()));
        chk("busy", 64'(busy_o), 64'(mstate == S_FILL || mstate == S_ROT));
        chk("rotating", 64'(rotating_o), 64'(mstate == S_ROT));
        chk("done", 64'(done_o), 64'(mdone));
    endtask

    task automatic idle_inputs();
        tick_i = 1'b0; pause_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; mode_i = 1'b0;
        load_i = 1'b0; msg_len_i = 4'd0; load_addr_i = 3'd0; load_char_i = '0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_start(input int len, input int mode);
        idle_inputs();
        start_i = 1'b1; msg_len_i = 4'(len); mode_i = mode[0];
        cyc();
        idle_inputs();
    endtask

    task automatic do_ticks(input int n);
        idle_inputs();
        tick_i = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        idle_inputs();
    endtask

    task automatic do_stop();
        idle_inputs();
        stop_i = 1'b1; tick_i = 1'b1;
        cyc();
        idle_inputs();
    endtask

    initial begin
        logic [ND*CW-1:0] saved;
        int done_count;
        int hello [5] = '{8, 5, 12, 12, 15};

        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        #2;
        check_all();
        rst_n = 1'b1;
        cyc();

        phase = "hello";
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            load_i = 1'b1; load_addr_i = 3'(i); load_char_i = CW'(hello[i]);
            cyc();
        end
        do_start(5, 1);
        do_ticks(8);
        chk("hello8", 64'(window_o), 64'(pack8(8, 5, 12, 12, 15, 0, 0, 0)));
        chk("hello8_rot", 64'(rotating_o), 64'd1);
        do_ticks(1);
        chk("hello9", 64'(window_o), 64'(pack8(5, 12, 12, 15, 0, 0, 0, 8)));
        do_stop();
        chk("stop_state", 64'(current_state_o), 64'd0);

        phase = "oneshot";
        do_start(2, 0);
        done_count = 0;
        for (int i = 0; i < 32; i++) begin
            idle_inputs();
            tick_i = (i % 4 == 3);
            cyc();
            if (done_o === 1'b1) done_count++;
            if (i == 19) chk("done_after_5th", 64'(done_o), 64'd1);
        end
        chk("done_count", 64'(done_count), 64'd1);
        chk("hold_window", 64'(window_o), 64'(pack8(0, 0, 0, 8, 5, 0, 0, 0)));
        chk("hold_state", 64'(current_state_o), 64'd3);
        do_start(2, 0);
        chk("hold_start_idle", 64'(current_state_o), 64'd0);

        phase = "pause";
        do_start(5, 0);
        do_ticks(3);
        saved = window_o;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            tick_i = 1'b1; pause_i = 1'b1;
            cyc();
            chk("paused_window", 64'(window_o), 64'(saved));
        end
        do_ticks(2);
        do_stop();
        chk("stop_window", 64'(window_o), 64'd0);
        chk("stop_busy", 64'(busy_o), 64'd0);

        phase = "guards";
        do_start(5, 1);
        do_ticks(2);
        idle_inputs();
        load_i = 1'b1; load_addr_i = 3'd2; load_char_i = CW'(31);
        cyc();
        do_ticks(3);
        do_stop();
        do_start(5, 0);
        do_ticks(8);
        chk("busy_load_dropped", 64'(window_o), 64'(pack8(8, 5, 12, 12, 15, 0, 0, 0)));
        do_start(5, 0);
        do_start(0, 1);
        chk("len0_idle", 64'(current_state_o), 64'd0);
        do_start(9, 1);
        chk("len9_idle", 64'(current_state_o), 64'd0);
        idle_inputs();
        load_i = 1'b1; load_addr_i = 3'd0; load_char_i = CW'(21);
        start_i = 1'b1; msg_len_i = 4'd1; mode_i = 1'b1;
        cyc();
        do_ticks(1);
        chk("load_start_char", 64'(window_o[CW-1:0]), 64'd21);
        do_stop();

        phase = "reset_mid";
        do_start(3, 1);
        do_ticks(12);
        chk("rot_before_reset", 64'(rotating_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        rst_n = 1'b1;
        do_start(3, 1);
        do_ticks(8);
        chk("blank_after_reset", 64'(window_o), 64'd0);
        do_stop();

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            tick_i      = ($urandom_range(0, 2) != 0);
            pause_i     = ($urandom_range(0, 7) == 0);
            start_i     = ($urandom_range(0, 9) == 0);
            stop_i      = ($urandom_range(0, 49) == 0);
            mode_i      = 1'($urandom_range(0, 1));
            msg_len_i   = 4'($urandom_range(0, 9));
            load_i      = ($urandom_range(0, 3) == 0);
            load_addr_i = 3'($urandom_range(0, 7));
            load_char_i = CW'($urandom_range(0, 31));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hex_msg_scroller.md
# hex_msg_scroller

Parametrised scrolling-message controller for the 7-segment display bank. It stores a message of up to MAX_LEN character codes and shifts it into a NUM_DIGITS-wide display window, one character per step tick. The stream is the message followed by PAD blank characters. After one full pass it either holds (one-shot) or rotates the stream forever. It drives per-digit character codes into the existing character-to-segment decoders and generalises the fixed HELLO fill-then-rotate sequencer.

## Interface
- NUM_DIGITS, 8, number of display digits in the window
- MAX_LEN, 8, message memory depth (characters)
- PAD, 3, blank characters appended after the message; total stream length L = MsgLen + PAD
- CHAR_W, 5, character code width; code 0 = BLANK
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- Tick  in  1  step enable, one scroll step per cycle in which Tick=1
- Pause  in  1  while 1, Tick is ignored and the window freezes
- Start  in  1  begin scrolling; honoured only in IDLE
- Stop  in  1  abort to IDLE from any state
- Mode  in  1  0 = one-shot, 1 = rotate
- MsgLen  in  clog2(MAX_LEN+1)  message length, sampled on the accepted Start
- Load  in  1  message write strobe; honoured only in IDLE
- LoadAddr  in  clog2(MAX_LEN)  write address
- LoadChar  in  CHAR_W  write data
- Window  out  NUM_DIGITS*CHAR_W  digit codes; digit 0 (rightmost) = bits [CHAR_W-1:0]
- Busy  out  1  state is FILL or ROTATE
- Rotating  out  1  state is ROTATE
- Done  out  1  one-cycle pulse on entry to HOLD
- CurrentState  out  2  state register, exported for debug and FSM recognition

## Operation
- States: IDLE, FILL, ROTATE, HOLD.
- **IDLE:** Window is all BLANK.
  - Load writes mem[LoadAddr] = LoadChar. Writes with LoadAddr ≥ MAX_LEN are dropped.
  - Start with 1 ≤ MsgLen ≤ MAX_LEN latches MsgLen and Mode, clears pos to 0, and moves to FILL.
  - Start with MsgLen = 0 or MsgLen > MAX_LEN is ignored.
- **Step** (FILL or ROTATE, Tick=1, Pause=0):
  - Window shifts one digit toward the higher index; digit NUM_DIGITS-1 is discarded.
  - Digit 0 takes stream[pos], where stream[pos] = mem[pos] if pos < MsgLen, else BLANK.
  - pos = (pos+1) mod L.
- **FILL:**
  - The step that emits stream[L-1] moves to ROTATE if Mode=1.
  - If Mode=0, the same step moves to HOLD and pulses Done.
- **ROTATE:** steps continue indefinitely, with pos wrapping modulo L.
- **HOLD:**
  - Window is frozen and Tick is ignored.
  - Start returns to IDLE: the window clears, and the next Start is required to begin again.
- **Stop:** from any non-IDLE state, next state is IDLE and Window clears.
- **Priority:** Stop > Start > step.
  - Stop together with Tick: no step occurs, and the state goes to IDLE.
  - Load together with Start in IDLE: the write lands in the same edge, and the new character is used.
- Load, Start and MsgLen are ignored outside the cases above. In particular, Load is ignored while Busy.
- If L < NUM_DIGITS, rotation simply repeats the stream with period L; no error is flagged.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE, pos = 0, MsgLen register = 0, Mode register = 0.
  - All memory = BLANK, Window = all BLANK.
  - Busy = 0, Rotating = 0, Done = 0.
- Start accepted at edge t: Busy = 1 from t.
- A step at edge t is visible on Window after t (one-cycle latency from Tick).
- The L-th step in FILL, at edge t:
  - Rotating = 1 after t (Mode=1), or
  - Done = 1 for exactly the cycle after t (Mode=0), and Busy = 0 from t.
- All outputs are registered; no combinational path from input to output.
- Reset asserted mid-scroll aborts immediately. Deassertion resumes in IDLE with the message memory cleared.

## Structure
- Package hex_msg_pkg holds:
  - State encodings IDLE = 2'd0, FILL = 2'd1, ROTATE = 2'd2, HOLD = 2'd3.
  - BLANK = 0.
  - Mode constants ONESHOT = 0, ROTATE_MODE = 1.
- Sub-module hex_msg_store: MAX_LEN × CHAR_W register file with resettable entries, one write port and one combinational read port addressed by pos.
- Top level holds the FSM, the pos counter and the window shift register.

## Test plan
- HELLO equivalence:
  - Setup: defaults, load 8,5,12,12,15 at 0–4, MsgLen=5, Mode=1, Start, Tick every cycle.
  - After 8 steps: digits 7..0 = 8,5,12,12,15,0,0,0 and Rotating=1.
  - Step 9: digits 7..0 = 5,12,12,15,0,0,0,8.
- One-shot:
  - Setup: MsgLen=2, Mode=0, Tick every 4th cycle.
  - Done pulses once, exactly one cycle after the 5th step.
  - Window holds 0,0,0,a,b,0,0,0, and further Tick causes no change.
- Pause and Stop:
  - Pause=1 for 10 cycles mid-FILL with Tick high: Window and pos are unchanged.
  - Stop together with Tick: next cycle is IDLE, Window all 0, Busy=0.
- Guards:
  - Load at addr 2 while Busy: memory unchanged after return to IDLE.
  - Start with MsgLen=0 or MsgLen=9: state stays IDLE.
  - Load and Start in the same cycle: the new character appears in the stream.
- Reset mid-ROTATE: asserting Reset low between edges clears all outputs immediately. After release, Start plays an all-BLANK message.
